// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
// Holds the subtractor state encoding and the largest supported operand width.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sersub_state_t;

  localparam int SERSUB_W_MAX = 32;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with the borrow out.
// Purely combinational, zero latency; it never applies backpressure.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first W-bit subtractor (diff = a - b); done pulses W+1 cycles after an accepted start.
// start is ignored while busy; the signed overflow output exists only when SERSUB_OVF_EN is defined.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
`ifdef SERSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sersub_state_t state_q;
  logic [W-1:0]  sa_q;
  logic [W-1:0]  sb_q;
  logic [W-1:0]  sd_q;
  logic [W-1:0]  diff_q;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          busy_q;
  logic          done_q;
  logic          borrow_q;

  logic          d_bit;
  logic          br_d;
  logic [W-1:0]  sd_d;

  full_subtractor_cell u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_d)
  );

  // The bit computed in the last SHIFT cycle lands in the MSB of the result.
  assign sd_d = {d_bit, sd_q[W-1:1]};

`ifdef SERSUB_OVF_EN
  logic [1:0] msb_q;
  logic       ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      msb_q    <= 2'b00;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            sa_q    <= a;
            sb_q    <= b;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERSUB_OVF_EN
            msb_q   <= {a[W-1], b[W-1]};
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sd_q  <= sd_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= sd_d;
            borrow_q <= br_d;
`ifdef SERSUB_OVF_EN
            // d_bit is the result MSB; overflow when operand signs differ and the result sign differs from a.
            ovf_q    <= (msb_q[1] ^ msb_q[0]) & (msb_q[1] ^ d_bit);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
